// File: rtl/gon_bus.sv
// Global output (gather) bus: round-robin selects one valid source whose
// scan-programmed tag ID matches the requested tag and hands its word to the host.

module gon_ctrl #(
    parameter int TAG_LENGTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rstb,
    input  logic                  i_shift,
    input  logic [TAG_LENGTH-1:0] i_tag_prev,
    input  logic [TAG_LENGTH-1:0] i_tag_q,
    input  logic                  i_valid,
    output logic [TAG_LENGTH-1:0] o_tag_id,
    output logic                  o_match
);
    logic [TAG_LENGTH-1:0] r_tag_id;

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb)      r_tag_id <= '0;
        else if (i_shift) r_tag_id <= i_tag_prev;
    end

    assign o_tag_id = r_tag_id;
    assign o_match  = i_valid && (r_tag_id == i_tag_q);
endmodule

module gon_bus #(
    parameter int BITWIDTH        = 16,
    parameter int TAG_LENGTH      = 4,
    parameter int NUM_CONTROLLERS = 10
) (
    input  logic                                i_clk,
    input  logic                                i_rstb,
    input  logic                                i_program,
    input  logic [TAG_LENGTH-1:0]               i_scan_tag_in,
    output logic [TAG_LENGTH-1:0]               o_scan_tag_next_bus,
    input  logic                                i_bus_enable,
    input  logic [TAG_LENGTH-1:0]               i_tag,
    output logic                                o_bus_ready,
    input  logic [NUM_CONTROLLERS-1:0]          i_source_valid,
    input  logic [BITWIDTH*NUM_CONTROLLERS-1:0] i_source_value,
    output logic [NUM_CONTROLLERS-1:0]          o_source_ack,
    output logic                                o_bus_valid,
    output logic [BITWIDTH-1:0]                 o_data_out,
    input  logic                                i_sink_ready
);
    localparam int N  = NUM_CONTROLLERS;
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_HOLD} state_t;

    state_t                         r_state, w_state_nxt;
    logic [TAG_LENGTH-1:0]          r_tag_q;
    logic [SW-1:0]                  r_rr, r_sel, w_sel;
    logic [BITWIDTH-1:0]            r_data;
    logic [N-1:0][TAG_LENGTH-1:0]   w_tag_id, w_chain_in;
    logic [N-1:0][BITWIDTH-1:0]     w_src;
    logic [N-1:0]                   w_match;
    logic [SW:0]                    w_idx;
    logic                           w_any, w_load_tag, w_load_data, w_xfer;

    assign w_src      = i_source_value;
    assign w_chain_in = {w_tag_id[N-2:0], i_scan_tag_in};

    generate
        for (genvar g = 0; g < N; g++) begin : g_ctrl
            gon_ctrl #(.TAG_LENGTH(TAG_LENGTH)) u_ctrl (
                .i_clk      (i_clk),
                .i_rstb     (i_rstb),
                .i_shift    (i_program),
                .i_tag_prev (w_chain_in[g]),
                .i_tag_q    (r_tag_q),
                .i_valid    (i_source_valid[g]),
                .o_tag_id   (w_tag_id[g]),
                .o_match    (w_match[g])
            );
        end
    endgenerate

    // Walk backwards from the farthest cyclic offset so the match nearest rr_ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr} + (SW+1)'(k);
            if (w_idx >= (SW+1)'(N)) w_idx = w_idx - (SW+1)'(N);
            if (w_match[w_idx[SW-1:0]]) begin
                w_any = 1'b1;
                w_sel = w_idx[SW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_tag  = 1'b0;
        w_load_data = 1'b0;
        w_xfer      = 1'b0;
        if (i_program) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (i_bus_enable) begin
                    w_load_tag  = 1'b1;
                    w_state_nxt = S_SEARCH;
                end
                S_SEARCH: if (!i_bus_enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_any) begin
                    w_load_data = 1'b1;
                    w_state_nxt = S_HOLD;
                end
                S_HOLD: if (i_sink_ready) begin
                    w_xfer      = 1'b1;
                    w_load_tag  = i_bus_enable;
                    w_state_nxt = i_bus_enable ? S_SEARCH : S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_state <= S_IDLE;
            r_tag_q <= '0;
            r_rr    <= '0;
            r_sel   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_tag) r_tag_q <= i_tag;
            if (w_load_data) begin
                r_data <= w_src[w_sel];
                r_sel  <= w_sel;
            end
            if (w_xfer) r_rr <= (r_sel == SW'(N - 1)) ? '0 : r_sel + SW'(1);
        end
    end

    // A word dropped by program must never be acked.
    always_comb begin
        o_source_ack        = '0;
        o_source_ack[r_sel] = w_xfer;
    end

    assign o_bus_ready         = (r_state == S_IDLE) && !i_program;
    assign o_bus_valid         = (r_state == S_HOLD);
    assign o_data_out          = r_data;
    assign o_scan_tag_next_bus = w_tag_id[N-1];
endmodule

// File: tb/tb_gon_bus.sv
// Randomized self-checking bench for gon_bus against a transaction-level model
// (tag table, round-robin pointer, cyclic first-match pick).

module tb_gon_bus;
    localparam int N  = 10;
    localparam int BW = 16;
    localparam int TL = 4;

    logic              clk, rstb, prog, en, sink, ready_o, bv;
    logic [TL-1:0]     scan_in, scan_next, tag;
    logic [N-1:0]      sv, ack;
    logic [BW*N-1:0]   sval;
    logic [BW-1:0]     dout;

    int checks = 0;
    int errors = 0;

    logic [TL-1:0] m_tag [N];
    int            m_rr;
    logic [BW-1:0] src_w [N];

    gon_bus #(.BITWIDTH(BW), .TAG_LENGTH(TL), .NUM_CONTROLLERS(N)) dut (
        .i_clk(clk), .i_rstb(rstb), .i_program(prog), .i_scan_tag_in(scan_in),
        .o_scan_tag_next_bus(scan_next), .i_bus_enable(en), .i_tag(tag),
        .o_bus_ready(ready_o), .i_source_valid(sv), .i_source_value(sval),
        .o_source_ack(ack), .o_bus_valid(bv), .o_data_out(dout),
        .i_sink_ready(sink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [TL-1:0] t, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (v[i] && m_tag[i] == t) return i;
        end
        return -1;
    endfunction

    task automatic drive_src();
        for (int i = 0; i < N; i++) sval[i*BW +: BW] = src_w[i];
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_tag[i] = '0;
        m_rr = 0;
    endtask

    task automatic check_reset_outputs(input string nm);
        checks++;
        if (dout !== '0 || bv !== 1'b0 || ack !== '0 || ready_o !== 1'b1 || scan_next !== '0) begin
            errors++;
            $display("FAIL %s: got dout=%h valid=%b ack=%b ready=%b scan=%h want 0/0/0/1/0",
                     nm, dout, bv, ack, ready_o, scan_next);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstb = 1'b0; prog = 0; en = 0; sink = 0; sv = '0; sval = '0; tag = '0; scan_in = '0;
        #1 check_reset_outputs("reset_state");
        @(negedge clk);
        rstb = 1'b1;
        model_reset();
    endtask

    task automatic scan_word(input logic [TL-1:0] v);
        @(negedge clk);
        #1;
        checks++;
        if (scan_next !== m_tag[N-1]) begin
            errors++; $display("FAIL scan_chain: got %h want %h", scan_next, m_tag[N-1]);
        end
        prog = 1'b1; scan_in = v; en = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++; $display("FAIL ready_in_program: got %b want 0", ready_o);
        end
        for (int i = N - 1; i > 0; i--) m_tag[i] = m_tag[i-1];
        m_tag[0] = v;
    endtask

    task automatic scan_end();
        @(negedge clk);
        prog = 1'b0;
        #1;
        checks++;
        if (scan_next !== m_tag[N-1] || ready_o !== 1'b1) begin
            errors++; $display("FAIL scan_end: got scan=%h ready=%b want %h/1", scan_next, ready_o, m_tag[N-1]);
        end
    endtask

    task automatic test_scan();
        for (int v = N - 1; v >= 0; v--) scan_word(TL'(v));
        scan_end();
    endtask

    // One gather from IDLE: fixed 2-edge latency, optional stall, then ack.
    task automatic gather(input logic [TL-1:0] t, input logic [N-1:0] mask, input int stall,
                          input int fix_idx, input logic [BW-1:0] fix_val);
        int g;
        logic [N-1:0] oh;
        logic [BW-1:0] want;
        for (int i = 0; i < N; i++) src_w[i] = BW'($urandom);
        if (fix_idx >= 0) src_w[fix_idx] = fix_val;
        g = pick(t, mask);
        @(negedge clk);
        drive_src(); sv = mask; en = 1'b1; tag = t; sink = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL gather_idle_ready: got %b want 1", ready_o); end
        @(negedge clk); #1;
        checks++;
        if (bv !== 1'b0) begin errors++; $display("FAIL gather_search_valid: got %b want 0", bv); end
        @(negedge clk);
        en = 1'b0;
        #1;
        if (g < 0) begin
            errors++; $display("FAIL gather_model: no matching source for tag %h", t);
            return;
        end
        want = src_w[g];
        oh = '0; oh[g] = 1'b1;
        checks++;
        if (bv !== 1'b1 || dout !== want) begin
            errors++; $display("FAIL gather_word: got valid=%b data=%h want 1/%h", bv, dout, want);
        end
        for (int s = 0; s < stall; s++) begin
            checks++;
            if (ack !== '0 || bv !== 1'b1 || dout !== want) begin
                errors++; $display("FAIL gather_stall: got ack=%b valid=%b data=%h want 0/1/%h", ack, bv, dout, want);
            end
            @(negedge clk);
            sv = '0;
            for (int i = 0; i < N; i++) src_w[i] = BW'($urandom);
            drive_src();
            #1;
        end
        sink = 1'b1;
        #1;
        checks++;
        if (ack !== oh || dout !== want) begin
            errors++; $display("FAIL gather_ack: got ack=%b data=%h want %b/%h", ack, dout, oh, want);
        end
        @(negedge clk);
        sink = 1'b0;
        #1;
        checks++;
        if (bv !== 1'b0 || ack !== '0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL gather_done: got valid=%b ack=%b ready=%b want 0/0/1", bv, ack, ready_o);
        end
        m_rr = (g + 1) % N;
    endtask

    task automatic test_single();
        gather(4'd3, '1, 0, 3, 16'd13);
    endtask

    task automatic test_stall();
        gather(4'd7, '1, 4, -1, '0);
    endtask

    task automatic test_no_match();
        @(negedge clk);
        en = 1'b1; tag = 4'd12; sv = '1; sink = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            checks++;
            if (bv !== 1'b0 || ack !== '0 || ready_o !== 1'b0) begin
                errors++; $display("FAIL no_match_search: got valid=%b ack=%b ready=%b want 0/0/0", bv, ack, ready_o);
            end
        end
        en = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (ready_o !== 1'b1 || bv !== 1'b0) begin
            errors++; $display("FAIL no_match_idle: got ready=%b valid=%b want 1/0", ready_o, bv);
        end
        sink = 1'b0;
    endtask

    task automatic test_random_unique();
        repeat (6) begin
            logic [TL-1:0] t;
            logic [N-1:0] mask;
            t = TL'($urandom_range(0, N - 1));
            mask = N'($urandom);
            mask[t] = 1'b1;
            gather(t, mask, $urandom_range(0, 2), -1, '0);
        end
    endtask

    task automatic test_back_to_back();
        test_reset();
        for (int i = 0; i < N; i++) scan_word(4'd5);
        scan_end();
        for (int i = 0; i < N; i++) src_w[i] = BW'($urandom);
        drive_src();
        @(negedge clk);
        sv = '1; en = 1'b1; tag = 4'd5; sink = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bv !== 1'b0) begin errors++; $display("FAIL b2b_first_search: got %b want 0", bv); end
        for (int w = 0; w < N + 1; w++) begin
            int g;
            logic [N-1:0] oh;
            g = pick(4'd5, sv);
            oh = '0; oh[g] = 1'b1;
            @(negedge clk); #1;
            checks++;
            if (bv !== 1'b1 || dout !== src_w[g] || ack !== oh) begin
                errors++; $display("FAIL b2b_word%0d: got valid=%b data=%h ack=%b want 1/%h/%b", w, bv, dout, ack, src_w[g], oh);
            end
            m_rr = (g + 1) % N;
            @(negedge clk); #1;
            checks++;
            if (bv !== 1'b0 || ack !== '0) begin
                errors++; $display("FAIL b2b_gap%0d: got valid=%b ack=%b want 0/0", w, bv, ack);
            end
        end
        en = 1'b0; sink = 1'b0;
    endtask

    task automatic test_rr_random();
        repeat (8) begin
            logic [N-1:0] mask;
            mask = N'($urandom);
            if (mask == '0) mask[$urandom_range(0, N - 1)] = 1'b1;
            gather(4'd5, mask, $urandom_range(0, 2), -1, '0);
        end
    endtask

    task automatic test_program_hold();
        for (int i = 0; i < N; i++) src_w[i] = BW'($urandom);
        drive_src();
        @(negedge clk);
        sv = '1; en = 1'b1; tag = 4'd5; sink = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (bv !== 1'b1) begin errors++; $display("FAIL prog_reach_hold: got %b want 1", bv); end
        prog = 1'b1; sink = 1'b1; en = 1'b0; scan_in = 4'd3;
        #1;
        checks++;
        if (ack !== '0 || ready_o !== 1'b0) begin
            errors++; $display("FAIL prog_no_ack: got ack=%b ready=%b want 0/0", ack, ready_o);
        end
        for (int i = N - 1; i > 0; i--) m_tag[i] = m_tag[i-1];
        m_tag[0] = 4'd3;
        @(negedge clk);
        prog = 1'b0; sink = 1'b0;
        #1;
        checks++;
        if (bv !== 1'b0 || ack !== '0 || ready_o !== 1'b1 || scan_next !== m_tag[N-1]) begin
            errors++; $display("FAIL prog_dropped: got valid=%b ack=%b ready=%b scan=%h want 0/0/1/%h",
                               bv, ack, ready_o, scan_next, m_tag[N-1]);
        end
        // The shifted-in tag 3 now sits in ctrl 0 and must be gatherable.
        gather(4'd3, '1, 0, -1, '0);
    endtask

    task automatic test_reset_mid_search();
        @(negedge clk);
        en = 1'b1; tag = 4'hE; sv = '1;
        @(negedge clk); #1;
        checks++;
        if (ready_o !== 1'b0 || bv !== 1'b0) begin
            errors++; $display("FAIL mid_search_state: got ready=%b valid=%b want 0/0", ready_o, bv);
        end
        rstb = 1'b0;
        #1 check_reset_outputs("reset_mid_search");
        @(negedge clk);
        rstb = 1'b1; en = 1'b0;
        model_reset();
        gather(4'd0, N'($urandom) | N'(1), 1, -1, '0);
    endtask

    initial begin
        rstb = 1'b0; prog = 0; en = 0; sink = 0; sv = '0; sval = '0; tag = '0; scan_in = '0;
        model_reset();
        test_reset();
        test_scan();
        test_single();
        test_stall();
        test_no_match();
        test_random_unique();
        test_back_to_back();
        test_rr_random();
        test_program_hold();
        test_reset_mid_search();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
